// File: rtl/hidden_backprop.sv
// hidden_backprop: backward-pass weight update for the four input-to-hidden weights of one hidden neuron.
module hidden_backprop #(
  parameter int W_WIDTH   = 8,
  parameter int ERR_WIDTH = 23,
  parameter int HID_WIDTH = 10,
  parameter int LR_SHIFT  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   zero_weight_reset_i,
  input  logic [4*W_WIDTH-1:0]   init_weights_i,
  input  logic [ERR_WIDTH-1:0]   err_i,
  input  logic [W_WIDTH-1:0]     w_out_i,
  input  logic [HID_WIDTH-1:0]   hidden_val_i,
  input  logic [3:0]             x_i,
  output logic [4*W_WIDTH-1:0]   weights_o,
  output logic                   busy_o,
  output logic                   b_end_o
);
  localparam int PW = ERR_WIDTH + W_WIDTH;
  localparam logic [2:0] IDLE = 3'd0, MULT = 3'd1, UPD = 3'd2, DONE = 3'd3, WAIT_LOW = 3'd4;
  localparam logic signed [PW:0] WMAX = (PW+1)'(2**(W_WIDTH-1)-1);
  localparam logic signed [PW:0] WMIN = -WMAX - 1;
  logic [2:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic signed [ERR_WIDTH-1:0] err_q, err_d;
  logic signed [W_WIDTH-1:0] wout_q, wout_d;
  logic [HID_WIDTH-1:0] hid_q, hid_d;
  logic [3:0] x_q, x_d;
  logic signed [PW-1:0] delta_q, delta_d, prod_c;
  logic [3:0][W_WIDTH-1:0] w_q, w_d;
  logic signed [PW:0] diff_c;
  logic [W_WIDTH-1:0] sat_c;
  assign prod_c = err_q * wout_q;
  // one guard bit above the delta width keeps w - delta exact before clamping
  assign diff_c = $signed(w_q[idx_q]) - delta_q;
  assign sat_c = diff_c > WMAX ? WMAX[W_WIDTH-1:0] : diff_c < WMIN ? WMIN[W_WIDTH-1:0] : diff_c[W_WIDTH-1:0];
  assign weights_o = w_q;
  assign busy_o = state_q == MULT || state_q == UPD;
  assign b_end_o = state_q == DONE;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    wout_d = wout_q;
    hid_d = hid_q;
    x_d = x_q;
    delta_d = delta_q;
    w_d = w_q;
    case (state_q)
      IDLE: if (en_i) begin
        err_d = err_i;
        wout_d = w_out_i;
        hid_d = hidden_val_i;
        x_d = x_i;
        state_d = MULT;
      end
      MULT: begin
        delta_d = prod_c >>> LR_SHIFT;
        idx_d = 2'd0;
        state_d = UPD;
      end
      UPD: begin
        if (x_q[idx_q] && hid_q != '0) w_d[idx_q] = sat_c;
        idx_d = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? DONE : UPD;
      end
      DONE: state_d = en_i ? WAIT_LOW : IDLE;
      WAIT_LOW: state_d = en_i ? WAIT_LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_q <= '0;
      wout_q <= '0;
      hid_q <= '0;
      x_q <= '0;
      delta_q <= '0;
      w_q <= '0;
    end else if (zero_weight_reset_i) begin
      state_q <= IDLE;
      w_q <= init_weights_i;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      wout_q <= wout_d;
      hid_q <= hid_d;
      x_q <= x_d;
      delta_q <= delta_d;
      w_q <= w_d;
    end
  end
endmodule

// File: tb/tb_hidden_backprop.sv
// tb_hidden_backprop: directed and randomized passes checked against an arithmetic weight-update model.
module tb_hidden_backprop;
  logic clk = 0, rst_i = 1, en_i = 0, zwr_i = 0;
  logic [31:0] init_i = 0;
  logic [22:0] err_i = 0;
  logic [7:0] wout_i = 0;
  logic [9:0] hid_i = 0;
  logic [3:0] x_i = 0;
  logic [31:0] weights_o;
  logic busy_o, b_end_o;
  int tests = 0, fails = 0;
  logic [31:0] mw = 0;
  always #5 clk = ~clk;
  hidden_backprop dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .zero_weight_reset_i(zwr_i),
    .init_weights_i(init_i), .err_i(err_i), .w_out_i(wout_i), .hidden_val_i(hid_i),
    .x_i(x_i), .weights_o(weights_o), .busy_o(busy_o), .b_end_o(b_end_o)
  );
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] w, input longint e, input longint wo,
                                         input logic [9:0] h, input logic [3:0] x);
    logic [31:0] r = w;
    longint p = e * wo;
    longint d = p / 64;
    if (p % 64 != 0 && p < 0) d--;
    for (int k = 0; k < 4; k++) begin
      longint v = longint'($signed(w[k*8+:8])) - d;
      v = v > 127 ? 127 : v < -128 ? -128 : v;
      if (x[k] && h != 0) r[k*8+:8] = v[7:0];
    end
    return r;
  endfunction
  task automatic load(input logic [31:0] v);
    @(negedge clk);
    zwr_i = 1;
    init_i = v;
    @(negedge clk);
    zwr_i = 0;
    chk("zwr_load", weights_o, v);
    mw = v;
  endtask
  task automatic pass(input string tag, input logic signed [22:0] e, input logic signed [7:0] wo,
                      input logic [9:0] h, input logic [3:0] x, input int hold, input int ncyc);
    int first = 0, nb = 0, nbusy = 0;
    logic [31:0] nw;
    @(negedge clk);
    err_i = e;
    wout_i = wo;
    hid_i = h;
    x_i = x;
    en_i = 1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n >= hold) en_i = 0;
      if (n == 1) begin
        err_i = 23'($urandom);
        wout_i = 8'($urandom);
        hid_i = 10'($urandom);
        x_i = 4'($urandom);
      end
      if (busy_o) nbusy++;
      if (b_end_o) begin
        nb++;
        if (first == 0) first = n;
      end
      if (n == 2) chk({tag, "_pre"}, weights_o, mw);
    end
    nw = model(mw, longint'(e), longint'(wo), h, x);
    chk({tag, "_lat"}, first, 6);
    chk({tag, "_nend"}, nb, 1);
    chk({tag, "_busy"}, nbusy, 5);
    chk({tag, "_w"}, weights_o, nw);
    mw = nw;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_w", weights_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_end", b_end_o, 0);
    rst_i = 0;
    load({8'd40, 8'd30, 8'd20, 8'd10});
    pass("basic", 23'sd64, 8'sd2, 10'd5, 4'b0101, 1, 10);
    chk("basic_const", weights_o, {8'd40, 8'd28, 8'd20, 8'd8});
    load(0);
    pass("negfloor", -23'sd1, 8'sd1, 10'd5, 4'b1111, 1, 10);
    chk("negfloor_const", weights_o, 32'h01010101);
    load(32'h00000500);
    pass("satlo", 23'h3fffff, 8'sd127, 10'd5, 4'b0011, 1, 10);
    chk("satlo_const", weights_o, 32'h00008080);
    pass("sathi", 23'h400000, 8'sd127, 10'd5, 4'b0011, 1, 10);
    chk("sathi_const", weights_o, 32'h00007f7f);
    load({8'd40, 8'd30, 8'd20, 8'd10});
    pass("relu", 23'sd64, 8'sd2, 10'd0, 4'b1111, 1, 10);
    chk("relu_const", weights_o, {8'd40, 8'd30, 8'd20, 8'd10});
    pass("level1", 23'sd640, 8'sd1, 10'd3, 4'b1001, 20, 24);
    pass("level2", 23'sd640, 8'sd1, 10'd3, 4'b1001, 1, 10);
    chk("level_const", weights_o, {8'd20, 8'd30, 8'd20, 8'd246});
    // abandon a pass while idx=1 is being processed
    @(negedge clk);
    err_i = 23'sd640; wout_i = 8'sd1; hid_i = 10'd1; x_i = 4'b1111; en_i = 1;
    @(negedge clk);
    en_i = 0;
    repeat (2) @(negedge clk);
    zwr_i = 1;
    init_i = 32'h11223344;
    @(negedge clk);
    zwr_i = 0;
    chk("abort_w", weights_o, 32'h11223344);
    chk("abort_busy", busy_o, 0);
    chk("abort_end", b_end_o, 0);
    begin
      int nb = 0;
      repeat (8) begin
        @(negedge clk);
        if (b_end_o) nb++;
      end
      chk("abort_noend", nb, 0);
    end
    mw = 32'h11223344;
    @(negedge clk);
    err_i = 23'sd640; wout_i = 8'sd1; hid_i = 10'd1; x_i = 4'b1111; en_i = 1;
    @(negedge clk);
    en_i = 0;
    repeat (3) @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    chk("midrst_w", weights_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_end", b_end_o, 0);
    mw = 0;
    for (int i = 0; i < 16; i++) begin
      logic [9:0] h;
      h = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
      if (i % 4 == 0) load($urandom);
      pass("rand", 23'($urandom), 8'($urandom), h, 4'($urandom), 1, 10);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
